// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared sweep-FSM state encoding, default parameters and address helpers.
// Rev 1.0
`default_nettype none

package regfile_pkg;

  localparam int c_DEF_XLEN   = 32;
  localparam int c_DEF_DEPTH  = 32;
  localparam int c_DEF_NRD    = 2;
  localparam int c_DEF_BYPASS = 1;

  typedef enum logic [0:0] {
    SW_IDLE  = 1'b0,
    SW_SWEEP = 1'b1
  } sweep_state_e;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

  // Entry 0 is hard-wired zero, so it is never a legal write or busy target.
  function automatic logic addr_writable(input logic [31:0] addr, input int unsigned depth);
    return (addr != 32'd0) && (addr < depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- per-entry busy bits with set/clear priority, plus the sweep-clear FSM.
// Rev 1.0
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = c_DEF_DEPTH,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_req_i,
  input  logic             set_en_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             wclr0_en_i,
  input  logic [AW-1:0]    wclr0_addr_i,
  input  logic             wclr1_en_i,
  input  logic [AW-1:0]    wclr1_addr_i,
  output logic [DEPTH-1:0] busy_o,
  output logic             sweep_o,
  output logic [AW-1:0]    idx_o
);

  sweep_state_e     state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [DEPTH-1:0] busy_q, busy_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SW_IDLE;
      idx_q   <= AW'(1);
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      SW_IDLE: begin
        if (clr_req_i) begin
          state_d = SW_SWEEP;
          idx_d   = AW'(1);
        end
      end
      SW_SWEEP: begin
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = SW_IDLE;
          idx_d   = AW'(1);
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
    endcase
  end

  // Set beats a same-cycle write clear; set/clear inputs arrive pre-gated off during a sweep.
  always_comb begin
    busy_d = busy_q;
    for (int a = 1; a < DEPTH; a++) begin
      if (state_q == SW_SWEEP) begin
        if (idx_q == AW'(a)) busy_d[a] = 1'b0;
      end else if (set_en_i && (set_addr_i == AW'(a))) begin
        busy_d[a] = 1'b1;
      end else if ((wclr0_en_i && (wclr0_addr_i == AW'(a))) ||
                   (wclr1_en_i && (wclr1_addr_i == AW'(a)))) begin
        busy_d[a] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  assign busy_o  = busy_q;
  assign sweep_o = (state_q == SW_SWEEP);
  assign idx_o   = idx_q;

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// regfile_sb -- multi-read register file with dual write ports, busy scoreboard and sweep clear.
// Rev 1.0
`default_nettype none

module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = c_DEF_XLEN,
  parameter int DEPTH  = c_DEF_DEPTH,
  parameter int NRD    = c_DEF_NRD,
  parameter int BYPASS = c_DEF_BYPASS,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [XLEN-1:0]   wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic [XLEN-1:0]   wdata1,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  input  logic              clr_req,
  output logic              clr_busy
);

  logic             w_sweep;
  logic [AW-1:0]    w_idx;
  logic [DEPTH-1:0] w_busy;
  logic             w_we0_ok, w_we1_ok, w_set_ok;
  logic [XLEN-1:0]  mem_q [DEPTH];

  // Qualified enables also drop during reset so nothing forwards from an ignored write.
  assign w_we0_ok = rst && we0    && !w_sweep && addr_writable(32'(waddr0), DEPTH);
  assign w_we1_ok = rst && we1    && !w_sweep && addr_writable(32'(waddr1), DEPTH);
  assign w_set_ok = rst && sb_set && !w_sweep && addr_writable(32'(sb_addr), DEPTH);

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .clr_req_i    (clr_req),
    .set_en_i     (w_set_ok),
    .set_addr_i   (sb_addr),
    .wclr0_en_i   (w_we0_ok),
    .wclr0_addr_i (waddr0),
    .wclr1_en_i   (w_we1_ok),
    .wclr1_addr_i (waddr1),
    .busy_o       (w_busy),
    .sweep_o      (w_sweep),
    .idx_o        (w_idx)
  );

  assign clr_busy = w_sweep;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (w_sweep) begin
      mem_q[w_idx] <= '0;
    end else begin
      if (w_we0_ok) mem_q[waddr0] <= wdata0;
      if (w_we1_ok) mem_q[waddr1] <= wdata1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic            w_valid, w_hit0, w_hit1, w_set_hit;
    logic [XLEN-1:0] w_stored;

    assign w_ra      = rd_addr[i*AW +: AW];
    assign w_valid   = addr_in_range(32'(w_ra), DEPTH);
    assign w_stored  = w_valid ? mem_q[w_ra] : '0;
    assign w_hit0    = (BYPASS != 0) && w_we0_ok && (waddr0 == w_ra);
    assign w_hit1    = (BYPASS != 0) && w_we1_ok && (waddr1 == w_ra);
    assign w_set_hit = w_set_ok && (sb_addr == w_ra);

    assign rd_data[i*XLEN +: XLEN] = w_hit1 ? wdata1 : (w_hit0 ? wdata0 : w_stored);
    assign rd_busy[i] = w_valid && w_busy[w_ra] && !((w_hit0 || w_hit1) && !w_set_hit);
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- scoreboard-checked directed bench for regfile_sb (default and DEPTH=24/NRD=3 instances).
// Rev 1.0
`default_nettype none

module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: defaults (XLEN 32, DEPTH 32, NRD 2, BYPASS 1)
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_we0, a_we1, a_sb_set, a_clr_req, a_clr_busy;
  logic [4:0]  a_waddr0, a_waddr1, a_sb_addr;
  logic [31:0] a_wdata0, a_wdata1;

  // Instance B: DEPTH 24, NRD 3
  logic [14:0] b_rd_addr;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic        b_we0, b_we1, b_sb_set, b_clr_req, b_clr_busy;
  logic [4:0]  b_waddr0, b_waddr1, b_sb_addr;
  logic [31:0] b_wdata0, b_wdata1;

  regfile_sb u_dut_a (
    .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .we0(a_we0), .waddr0(a_waddr0), .wdata0(a_wdata0),
    .we1(a_we1), .waddr1(a_waddr1), .wdata1(a_wdata1),
    .sb_set(a_sb_set), .sb_addr(a_sb_addr), .clr_req(a_clr_req), .clr_busy(a_clr_busy)
  );

  regfile_sb #(.DEPTH(24), .NRD(3)) u_dut_b (
    .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .we0(b_we0), .waddr0(b_waddr0), .wdata0(b_wdata0),
    .we1(b_we1), .waddr1(b_waddr1), .wdata1(b_wdata1),
    .sb_set(b_sb_set), .sb_addr(b_sb_addr), .clr_req(b_clr_req), .clr_busy(b_clr_busy)
  );

  // sel: 0 A data, 1 A busy, 2 A clr_busy, 3 B data, 4 B busy, 5 B clr_busy
  typedef struct {
    int          sel;
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_v(input int sel, input int port, input logic [31:0] v, input string name);
    exp_t e;
    e.sel = sel; e.port = port; e.exp = v; e.name = name;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        0:       act = a_rd_data[e.port*32 +: 32];
        1:       act = {31'd0, a_rd_busy[e.port]};
        2:       act = {31'd0, a_clr_busy};
        3:       act = b_rd_data[e.port*32 +: 32];
        4:       act = {31'd0, b_rd_busy[e.port]};
        default: act = {31'd0, b_clr_busy};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ra(input int port, input logic [4:0] addr);
    a_rd_addr[port*5 +: 5] = addr;
  endtask

  task automatic rb(input int port, input logic [4:0] addr);
    b_rd_addr[port*5 +: 5] = addr;
  endtask

  task automatic idle();
    a_we0 = 0; a_we1 = 0; a_sb_set = 0; a_clr_req = 0;
    b_we0 = 0; b_we1 = 0; b_sb_set = 0; b_clr_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle();
    a_rd_addr = '0; b_rd_addr = '0;
    a_waddr0 = '0; a_waddr1 = '0; a_wdata0 = '0; a_wdata1 = '0; a_sb_addr = '0;
    b_waddr0 = '0; b_waddr1 = '0; b_wdata0 = '0; b_wdata1 = '0; b_sb_addr = '0;

    // Reset state; a write under reset must not forward
    tick();
    a_we0 = 1; a_waddr0 = 5; a_wdata0 = 32'h55; ra(1, 5);
    expect_v(0, 0, 0, "rst_data"); expect_v(1, 0, 0, "rst_busy");
    expect_v(0, 1, 0, "rst_nobypass"); expect_v(2, 0, 0, "rst_clr_busy_a");
    expect_v(5, 0, 0, "rst_clr_busy_b");
    tick();
    idle(); rst = 1'b1;

    // Write x5 then read on port 1
    tick();
    a_we0 = 1; a_waddr0 = 5; a_wdata0 = 32'hDEADBEEF; ra(1, 5);
    expect_v(0, 1, 32'hDEADBEEF, "x5_bypass");
    tick(); idle();
    expect_v(0, 1, 32'hDEADBEEF, "x5_read");
    tick();
    a_we0 = 1; a_waddr0 = 0; a_wdata0 = 32'h1; ra(0, 0);
    expect_v(0, 0, 0, "x0_same_cycle");
    tick(); idle();
    expect_v(0, 0, 0, "x0_read");

    // Dual write same address: port 1 wins
    tick();
    a_we0 = 1; a_waddr0 = 7; a_wdata0 = 32'h11;
    a_we1 = 1; a_waddr1 = 7; a_wdata1 = 32'h22; ra(0, 7);
    expect_v(0, 0, 32'h22, "x7_dual_bypass");
    tick(); idle();
    expect_v(0, 0, 32'h22, "x7_dual_stored");

    // Scoreboard set / clear / priority on x3
    tick();
    a_sb_set = 1; a_sb_addr = 3; ra(0, 3);
    expect_v(1, 0, 0, "x3_busy_pre");
    tick(); idle();
    expect_v(1, 0, 1, "x3_busy_set");
    tick();
    a_we0 = 1; a_waddr0 = 3; a_wdata0 = 32'h33;
    expect_v(1, 0, 0, "x3_busy_fwd_clear");
    tick(); idle();
    expect_v(1, 0, 0, "x3_busy_cleared"); expect_v(0, 0, 32'h33, "x3_data");
    tick();
    a_sb_set = 1; a_sb_addr = 3;
    tick();
    a_sb_set = 1; a_sb_addr = 3; a_we0 = 1; a_waddr0 = 3; a_wdata0 = 32'h44;
    expect_v(1, 0, 1, "x3_set_wr_same_cycle");
    tick(); idle();
    expect_v(1, 0, 1, "x3_set_wins"); expect_v(0, 0, 32'h44, "x3_data2");

    // Instance B: out-of-range address, boundary entry, independent ports
    tick();
    b_we0 = 1; b_waddr0 = 30; b_wdata0 = 32'h77;
    b_we1 = 1; b_waddr1 = 23; b_wdata1 = 32'hC;
    b_sb_set = 1; b_sb_addr = 30;
    rb(0, 30); rb(1, 23); rb(2, 0);
    expect_v(3, 0, 0, "b_oor_bypass"); expect_v(3, 1, 32'hC, "b_x23_bypass");
    tick(); idle();
    b_we0 = 1; b_waddr0 = 10; b_wdata0 = 32'hA;
    b_we1 = 1; b_waddr1 = 11; b_wdata1 = 32'hB;
    rb(1, 23); rb(2, 30);
    expect_v(3, 0, 0, "b_oor_read"); expect_v(4, 0, 0, "b_oor_busy");
    expect_v(3, 1, 32'hC, "b_x23_read"); expect_v(3, 2, 0, "b_oor_read_p2");
    tick(); idle();
    rb(0, 10); rb(1, 11); rb(2, 23);
    expect_v(3, 0, 32'hA, "b_p0_x10"); expect_v(3, 1, 32'hB, "b_p1_x11"); expect_v(3, 2, 32'hC, "b_p2_x23");
    tick();
    rb(0, 23); rb(1, 30); rb(2, 10);
    expect_v(3, 0, 32'hC, "b_p0_x23"); expect_v(3, 1, 0, "b_p1_x30"); expect_v(3, 2, 32'hA, "b_p2_x10");

    // Fill x1..x31 then sweep
    for (int i = 1; i < 32; i++) begin
      tick();
      a_we0 = 1; a_waddr0 = 5'(i); a_wdata0 = 32'h1000_0000 + 32'(i);
    end
    tick(); idle();
    ra(0, 31); ra(1, 1);
    a_sb_set = 1; a_sb_addr = 9; a_clr_req = 1;
    expect_v(0, 0, 32'h1000_001F, "fill_x31"); expect_v(0, 1, 32'h1000_0001, "fill_x1");
    expect_v(2, 0, 0, "clr_req_cycle_idle");
    for (int k = 0; k < 31; k++) begin
      tick();
      a_clr_req = (k < 5);
      a_we0 = 1; a_waddr0 = 1;  a_wdata0 = 32'hBAD1;
      a_we1 = 1; a_waddr1 = 31; a_wdata1 = 32'hBAD0_0000;
      a_sb_set = (k >= 10); a_sb_addr = 5;
      expect_v(2, 0, 1, "sweep_clr_busy");
      expect_v(0, 0, 32'h1000_001F, "sweep_hold_x31");
      expect_v(0, 1, (k == 0) ? 32'h1000_0001 : 32'h0, "sweep_x1");
    end
    tick(); idle();
    expect_v(2, 0, 0, "sweep_done");
    for (int j = 0; j < 16; j++) begin
      tick();
      ra(0, 5'(2*j)); ra(1, 5'(2*j + 1));
      expect_v(0, 0, 0, "post_sweep_data0"); expect_v(0, 1, 0, "post_sweep_data1");
      expect_v(1, 0, 0, "post_sweep_busy0"); expect_v(1, 1, 0, "post_sweep_busy1");
    end
    expect_v(2, 0, 0, "no_sweep_restart");

    // Reset in the middle of a sweep
    tick();
    a_we0 = 1; a_waddr0 = 20; a_wdata0 = 32'hAAAA;
    a_we1 = 1; a_waddr1 = 30; a_wdata1 = 32'hBBBB;
    tick(); idle();
    a_clr_req = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      a_clr_req = 0;
      expect_v(2, 0, 1, "sweep2_clr_busy");
    end
    tick();
    ra(0, 20); ra(1, 30);
    rst = 1'b0;
    #1;
    expect_v(2, 0, 0, "rst_mid_clr_busy");
    expect_v(0, 0, 0, "rst_mid_x20"); expect_v(0, 1, 0, "rst_mid_x30");
    tick();
    expect_v(2, 0, 0, "rst_held_clr_busy");
    tick();
    rst = 1'b1;
    expect_v(2, 0, 0, "rst_release_clr_busy");
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_v(2, 0, 0, "no_resume");
      expect_v(0, 0, 0, "post_rst_x20"); expect_v(0, 1, 0, "post_rst_x30");
    end
    tick();
    a_we0 = 1; a_waddr0 = 20; a_wdata0 = 32'h1234;
    tick(); idle();
    expect_v(0, 0, 32'h1234, "idle_write_after_rst");

    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
